regfile_mp: RTL and testbench

Parametrised multi-port register file that succeeds the fixed 32×64 register file in the datapath. It generalises width and depth and keeps two operand read ports, a primary write port, and a side (switch/debug) write port with a matching inspect read port. It adds a hardware initialisation sequencer that replaces simulation-only initial values, a clear request, a same-address write-conflict flag, and optional write-to-read bypass. It sits between decode (operand reads), writeback (primary write) and the board-level debug/switch interface (side port).

---
 rtl/regfile_mp.sv | 119 +++++++++++
 tb/tb_regfile_mp.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_mp.sv
// Parametrised register file with two operand read ports, primary and side write ports,
// hardware init sequencer, clear request and write-conflict flag. Define REGFILE_BYPASS_EN for write-to-read bypass.
module regfile_mp #(
  parameter int DATA_W = 64,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic [ADDR_W-1:0] r0addr,
  input  logic [ADDR_W-1:0] r1addr,
  output logic [DATA_W-1:0] r0data,
  output logic [DATA_W-1:0] r1data,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              wena,
  input  logic [ADDR_W-1:0] swaddr,
  input  logic [DATA_W-1:0] swdata,
  input  logic              swena,
  output logic [DATA_W-1:0] dff,
  output logic              ready,
  output logic              wr_conflict
);

  localparam int DEPTH = 2 ** ADDR_W;

  typedef enum logic {INIT, RUN} state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] init_ptr_q, init_ptr_d;
  logic              wr_conflict_q, wr_conflict_d;
  logic [DATA_W-1:0] mem_q [DEPTH];

  // Port A carries either the init sequencer or the primary write; port B is the side write.
  logic              pw_en;
  logic [ADDR_W-1:0] pw_addr;
  logic [DATA_W-1:0] pw_data;
  logic              sw_en;

  logic [ADDR_W-1:0] rd_addr [3];
  logic [DATA_W-1:0] rd_data [3];

  always_comb begin
    state_d       = state_q;
    init_ptr_d    = init_ptr_q;
    wr_conflict_d = 1'b0;
    pw_en         = 1'b0;
    pw_addr       = waddr;
    pw_data       = wdata;
    sw_en         = 1'b0;
    case (state_q)
      INIT: begin
        if (clr) begin
          init_ptr_d = '0;
        end else begin
          pw_en      = 1'b1;
          pw_addr    = init_ptr_q;
          pw_data    = DATA_W'(init_ptr_q);
          init_ptr_d = init_ptr_q + 1'b1;
          if (&init_ptr_q) state_d = RUN;
        end
      end
      RUN: begin
        if (clr) begin
          state_d    = INIT;
          init_ptr_d = '0;
        end else begin
          pw_en         = wena;
          sw_en         = swena;
          wr_conflict_d = wena & swena & (waddr == swaddr);
        end
      end
      default: state_d = INIT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= INIT;
      init_ptr_q    <= '0;
      wr_conflict_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      init_ptr_q    <= init_ptr_d;
      wr_conflict_q <= wr_conflict_d;
    end
  end

  // Side write is applied last so it wins on a same-address collision.
  always_ff @(posedge clk) begin
    if (pw_en) mem_q[pw_addr] <= pw_data;
    if (sw_en) mem_q[swaddr]  <= swdata;
  end

  assign rd_addr[0] = r0addr;
  assign rd_addr[1] = r1addr;
  assign rd_addr[2] = swaddr;

  always_comb begin
    for (int i = 0; i < 3; i++) begin
      rd_data[i] = '0;
      if (state_q == RUN) begin
        rd_data[i] = mem_q[rd_addr[i]];
`ifdef REGFILE_BYPASS_EN
        if (pw_en && (pw_addr == rd_addr[i])) rd_data[i] = pw_data;
        if (sw_en && (swaddr == rd_addr[i])) rd_data[i] = swdata;
`else
`endif
      end
    end
  end

  assign r0data      = rd_data[0];
  assign r1data      = rd_data[1];
  assign dff         = rd_data[2];
  assign ready       = (state_q == RUN);
  assign wr_conflict = wr_conflict_q;

endmodule

// File: tb/tb_regfile_mp.sv
// Self-checking bench for regfile_mp: scoreboard queue of expected values, one task per scenario.
module tb_regfile_mp;

  localparam int DATA_W = 64;
  localparam int ADDR_W = 5;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              clr;
  logic [ADDR_W-1:0] r0addr, r1addr, waddr, swaddr;
  logic [DATA_W-1:0] r0data, r1data, wdata, swdata, dff;
  logic              wena, swena, ready, wr_conflict;

  int tests = 0;
  int fails = 0;
  logic [DATA_W-1:0] sb_q [$];
  logic [DATA_W-1:0] exp_v;

  regfile_mp #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst_n(rst_n), .clr(clr),
    .r0addr(r0addr), .r1addr(r1addr), .r0data(r0data), .r1data(r1data),
    .waddr(waddr), .wdata(wdata), .wena(wena),
    .swaddr(swaddr), .swdata(swdata), .swena(swena),
    .dff(dff), .ready(ready), .wr_conflict(wr_conflict)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready(output int edges);
    edges = 0;
    for (int i = 0; i < 200; i++) begin
      tick();
      edges++;
      if (ready) break;
    end
  endtask

  task automatic test_reset();
    int edges;
    rst_n = 1'b0; clr = 1'b0; wena = 1'b0; swena = 1'b0;
    r0addr = 5; r1addr = 31; swaddr = 17; waddr = '0; wdata = '0; swdata = '0;
    #12;
    tests++;
    if (ready !== 1'b0) begin fails++; $display("FAIL reset_ready got %b exp 0", ready); end
    tests++;
    if (wr_conflict !== 1'b0) begin fails++; $display("FAIL reset_conflict got %b exp 0", wr_conflict); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    edges = 0;
    for (int i = 0; i < 200; i++) begin
      tick();
      edges++;
      if (edges == 1) begin
        sb_q.push_back('0); sb_q.push_back('0); sb_q.push_back('0);
        exp_v = sb_q.pop_front(); tests++;
        if (r0data !== exp_v) begin fails++; $display("FAIL init_r0_zero got %h exp %h", r0data, exp_v); end
        exp_v = sb_q.pop_front(); tests++;
        if (r1data !== exp_v) begin fails++; $display("FAIL init_r1_zero got %h exp %h", r1data, exp_v); end
        exp_v = sb_q.pop_front(); tests++;
        if (dff !== exp_v) begin fails++; $display("FAIL init_dff_zero got %h exp %h", dff, exp_v); end
      end
      if (ready) break;
    end
    tests++;
    if (edges != 32) begin fails++; $display("FAIL ready_edges got %0d exp 32", edges); end
    sb_q.push_back(64'd5); sb_q.push_back(64'd31); sb_q.push_back(64'd17);
    exp_v = sb_q.pop_front(); tests++;
    if (r0data !== exp_v) begin fails++; $display("FAIL run_r0_5 got %h exp %h", r0data, exp_v); end
    exp_v = sb_q.pop_front(); tests++;
    if (r1data !== exp_v) begin fails++; $display("FAIL run_r1_31 got %h exp %h", r1data, exp_v); end
    exp_v = sb_q.pop_front(); tests++;
    if (dff !== exp_v) begin fails++; $display("FAIL run_dff_17 got %h exp %h", dff, exp_v); end
  endtask

  task automatic test_write();
    wena = 1'b1; waddr = 3; wdata = 64'hDEAD; r0addr = 3;
`ifdef REGFILE_BYPASS_EN
    sb_q.push_back(64'hDEAD);
`else
    sb_q.push_back(64'd3);
`endif
    #1;
    exp_v = sb_q.pop_front(); tests++;
    if (r0data !== exp_v) begin fails++; $display("FAIL write_same_cycle got %h exp %h", r0data, exp_v); end
    sb_q.push_back(64'hDEAD);
    tick();
    wena = 1'b0;
    #1;
    exp_v = sb_q.pop_front(); tests++;
    if (r0data !== exp_v) begin fails++; $display("FAIL write_next_cycle got %h exp %h", r0data, exp_v); end
    // entry 0 is an ordinary register; side port writes and inspects entry 9
    wena = 1'b1; waddr = 0; wdata = 64'h0123_4567_89AB_CDEF;
    swena = 1'b1; swaddr = 9; swdata = 64'hFEDC_BA98_7654_3210;
    sb_q.push_back(64'h0123_4567_89AB_CDEF); sb_q.push_back(64'hFEDC_BA98_7654_3210);
    tick();
    wena = 1'b0; swena = 1'b0; r1addr = 0;
    #1;
    exp_v = sb_q.pop_front(); tests++;
    if (r1data !== exp_v) begin fails++; $display("FAIL write_entry0 got %h exp %h", r1data, exp_v); end
    exp_v = sb_q.pop_front(); tests++;
    if (dff !== exp_v) begin fails++; $display("FAIL side_write_dff got %h exp %h", dff, exp_v); end
    tests++;
    if (wr_conflict !== 1'b0) begin fails++; $display("FAIL diff_addr_noconflict got %b exp 0", wr_conflict); end
  endtask

  task automatic test_conflict();
    wena = 1'b1; waddr = 7; wdata = 64'h11;
    swena = 1'b1; swaddr = 7; swdata = 64'h22;
    sb_q.push_back(64'h22);
    tick();
    wena = 1'b0; swena = 1'b0; r0addr = 7;
    #1;
    exp_v = sb_q.pop_front(); tests++;
    if (r0data !== exp_v) begin fails++; $display("FAIL conflict_data got %h exp %h", r0data, exp_v); end
    tests++;
    if (wr_conflict !== 1'b1) begin fails++; $display("FAIL conflict_flag got %b exp 1", wr_conflict); end
    tick();
    tests++;
    if (wr_conflict !== 1'b0) begin fails++; $display("FAIL conflict_one_cycle got %b exp 0", wr_conflict); end
    wena = 1'b1; waddr = 7; wdata = 64'h11;
    swena = 1'b1; swaddr = 8; swdata = 64'h22;
    sb_q.push_back(64'h11); sb_q.push_back(64'h22);
    tick();
    wena = 1'b0; swena = 1'b0; r0addr = 7; r1addr = 8;
    #1;
    exp_v = sb_q.pop_front(); tests++;
    if (r0data !== exp_v) begin fails++; $display("FAIL dual_write_p got %h exp %h", r0data, exp_v); end
    exp_v = sb_q.pop_front(); tests++;
    if (r1data !== exp_v) begin fails++; $display("FAIL dual_write_s got %h exp %h", r1data, exp_v); end
    tests++;
    if (wr_conflict !== 1'b0) begin fails++; $display("FAIL dual_write_flag got %b exp 0", wr_conflict); end
  endtask

  task automatic test_clr();
    int edges;
    clr = 1'b1; wena = 1'b1; waddr = 2; wdata = 64'hFF;
    swena = 1'b1; swaddr = 2; swdata = 64'hEE;
    tick();
    clr = 1'b0; wena = 1'b0; swena = 1'b0;
    #1;
    tests++;
    if (ready !== 1'b0) begin fails++; $display("FAIL clr_ready_drop got %b exp 0", ready); end
    tests++;
    if (wr_conflict !== 1'b0) begin fails++; $display("FAIL clr_conflict got %b exp 0", wr_conflict); end
    wait_ready(edges);
    tests++;
    if (edges + 1 != 33) begin fails++; $display("FAIL clr_low_edges got %0d exp 33", edges + 1); end
    r0addr = 2;
    sb_q.push_back(64'd2);
    #1;
    exp_v = sb_q.pop_front(); tests++;
    if (r0data !== exp_v) begin fails++; $display("FAIL clr_discard got %h exp %h", r0data, exp_v); end
  endtask

  task automatic test_reset_mid_init();
    int edges;
    wena = 1'b1; waddr = 25; wdata = 64'hBEEF;
    tick();
    wena = 1'b0;
    rst_n = 1'b0;
    #1;
    tests++;
    if (ready !== 1'b0) begin fails++; $display("FAIL async_reset_ready got %b exp 0", ready); end
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) tick();
    rst_n = 1'b0;
    #1;
    tests++;
    if (ready !== 1'b0) begin fails++; $display("FAIL midinit_ready got %b exp 0", ready); end
    tick();
    rst_n = 1'b1;
    wait_ready(edges);
    tests++;
    if (edges != 32) begin fails++; $display("FAIL midinit_edges got %0d exp 32", edges); end
    for (int a = 0; a < 32; a++) sb_q.push_back(DATA_W'(a));
    for (int a = 0; a < 32; a++) begin
      r0addr = ADDR_W'(a);
      #1;
      exp_v = sb_q.pop_front(); tests++;
      if (r0data !== exp_v) begin fails++; $display("FAIL midinit_entry%0d got %h exp %h", a, r0data, exp_v); end
    end
  endtask

  task automatic test_init_writes();
    int edges;
    clr = 1'b1;
    tick();
    clr = 1'b0;
    wena = 1'b1; waddr = 20; wdata = 64'hAB;
    swena = 1'b1; swaddr = 21; swdata = 64'hCD;
    wait_ready(edges);
    wena = 1'b0; swena = 1'b0;
    tests++;
    if (edges != 32) begin fails++; $display("FAIL initw_edges got %0d exp 32", edges); end
    r0addr = 20;
    sb_q.push_back(64'd20); sb_q.push_back(64'd21);
    #1;
    exp_v = sb_q.pop_front(); tests++;
    if (r0data !== exp_v) begin fails++; $display("FAIL initw_entry20 got %h exp %h", r0data, exp_v); end
    exp_v = sb_q.pop_front(); tests++;
    if (dff !== exp_v) begin fails++; $display("FAIL initw_entry21 got %h exp %h", dff, exp_v); end
  endtask

  initial begin
    test_reset();
    test_write();
    test_conflict();
    test_clr();
    test_reset_mid_init();
    test_init_writes();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
